perf_dump_ctrl: RTL and testbench
=================================

Name: perf_dump_ctrl

Overview:
- Owns the five performance counters that feed the store path: clk_cycles, invalid_clk_cycles, retired_instructions, correct_predictions, total_predictions.
- On a dump request it snapshots all five counters and writes them to data memory through BRAM port B, at BASE_ADDR + 4*i for i = 0..4.
- It shares port B with CPU loads and stores. The CPU always has priority; the dump sequence stalls while the CPU holds the port.

Parameters:
- BASE_ADDR, 32'h4F00, byte address of counter 0. Must be word-aligned.
- CTR_W, 32, width of each counter. Counters wrap modulo 2^CTR_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ctr_clear  in  1  zero all live counters
- bubble  in  1  current cycle is an invalid (stalled or flushed) cycle
- retire  in  1  one instruction retires this cycle
- br_resolved  in  1  a branch prediction resolves this cycle
- br_correct  in  1  the resolving prediction was correct; qualified by br_resolved
- dump_req  in  1  start a dump; sampled only in IDLE
- cpu_mem_req  in  1  CPU owns port B this cycle (load or store)
- cpu_web  in  4  CPU byte write enables
- cpu_addrb  in  32  CPU port-B address
- cpu_dib  in  32  CPU write data
- web  out  4  port-B byte write enables
- addrb  out  32  port-B address
- dib  out  32  port-B write data
- clk_cycles, invalid_clk_cycles, retired_instructions, correct_predictions, total_predictions  out  CTR_W each  live counter values, registered
- dump_busy  out  1  high in SNAP and WRITE states
- dump_done  out  1  one-cycle pulse after the final word is written

Behaviour:
- Reset: all counters = 0, state = IDLE, index = 0, snapshot registers = 0, dump_busy = 0, dump_done = 0.
- Counter updates, each clock edge:
  - clk_cycles += 1
  - invalid_clk_cycles += bubble
  - retired_instructions += retire
  - total_predictions += br_resolved
  - correct_predictions += (br_resolved & br_correct); br_correct without br_resolved is ignored.
- ctr_clear has priority over increments: counters become 0 on that edge, not 1. ctr_clear does not affect an in-flight dump, which uses the snapshot.
- Wrap: a counter at all-ones rolls to 0 on its next increment. No sticky or saturation flag.
- State machine:
  - IDLE: dump_req=1 -> SNAP. Otherwise stay.
  - SNAP: one cycle. Latch the five counter values, as seen in this cycle before this edge's update, into snap[0..4] in the order listed above. Set index = 0. Go to WRITE. No port-B access.
  - WRITE: if cpu_mem_req=1, the dump is stalled (no write, index holds). Otherwise write snap[index] to BASE_ADDR + 4*index with web = 4'b1111. If index = 4 -> DONE, else index += 1.
  - DONE: dump_done = 1 for this cycle only. Go to IDLE. No port-B access.
- dump_req is ignored outside IDLE; a request is not queued.
- Port-B mux (combinational):
  - If cpu_mem_req=1 or state != WRITE: web/addrb/dib = cpu_web/cpu_addrb/cpu_dib.
  - Otherwise the dump drives the port.
  - When the CPU owns the port, cpu signals pass through unchanged, including web = 0 for loads.
- Latency, uncontended: dump_req seen in IDLE at edge k -> SNAP during cycle k+1 -> writes in cycles k+2..k+6 -> dump_done in cycle k+7. Total = 7 cycles from request to done pulse.
- Each CPU-contended WRITE cycle adds exactly one cycle. There is no starvation bound; the dump waits indefinitely while cpu_mem_req is held.
- rst mid-dump: return to IDLE immediately and zero the counters. No partial-write cleanup; memory keeps any words already written.
- A bubble cycle still increments clk_cycles.

Test Plan:
- Reset, then 10 cycles with bubble=1 on cycles 3 and 4 and retire=1 on the other 8 -> clk_cycles=10, invalid_clk_cycles=2, retired_instructions=8.
- br_resolved pulses 6 times with br_correct=1 on 4 of them, plus 2 cycles of br_correct=1 with br_resolved=0 -> total_predictions=6, correct_predictions=4.
- dump_req with cpu_mem_req=0 throughout -> addrb = 0x4F00, 0x4F04, 0x4F08, 0x4F0C, 0x4F10 in 5 consecutive cycles, web=4'hF, dib = the snapshot values; dump_done pulses exactly 7 cycles after the request.
- During WRITE, assert cpu_mem_req with cpu_web=4'b0011, cpu_addrb=0x100 for 3 cycles at index 2 -> port shows the CPU values unchanged; index 2 resumes afterwards; dump_done delayed by exactly 3 cycles; snapshot values unchanged.
- Preload retired_instructions=32'hFFFFFFFF, then retire=1 -> value becomes 0. Assert ctr_clear and retire together -> value stays 0 after the edge.
- dump_req asserted again mid-dump -> ignored, single dump_done. rst asserted at index 3 -> next cycle dump_busy=0, all counters=0, web=cpu_web.

Source files
------------

// File: rtl/perf_dump_ctrl.sv
// Performance counters with a snapshot-and-dump engine that writes them to data memory
// through BRAM port B, yielding the port to CPU loads/stores whenever they request it.
module perf_dump_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h4F00,
    parameter int          CTR_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctr_clear,
    input  logic             bubble,
    input  logic             retire,
    input  logic             br_resolved,
    input  logic             br_correct,
    input  logic             dump_req,
    input  logic             cpu_mem_req,
    input  logic [3:0]       cpu_web,
    input  logic [31:0]      cpu_addrb,
    input  logic [31:0]      cpu_dib,
    output logic [3:0]       web,
    output logic [31:0]      addrb,
    output logic [31:0]      dib,
    output logic [CTR_W-1:0] clk_cycles,
    output logic [CTR_W-1:0] invalid_clk_cycles,
    output logic [CTR_W-1:0] retired_instructions,
    output logic [CTR_W-1:0] correct_predictions,
    output logic [CTR_W-1:0] total_predictions,
    output logic             dump_busy,
    output logic             dump_done
);

    localparam int NCTR = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SNAP,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       index_q, index_d;
    logic             dump_wr;
    logic [NCTR-1:0]  inc;
    logic [CTR_W-1:0] ctr_q  [NCTR];
    logic [CTR_W-1:0] ctr_d  [NCTR];
    logic [CTR_W-1:0] snap_q [NCTR];
    logic [31:0]      snap_word;

    // Counter slot order doubles as the memory word order of a dump.
    assign inc = {br_resolved, br_resolved & br_correct, retire, bubble, 1'b1};

    generate
        for (genvar gi = 0; gi < NCTR; gi++) begin : g_ctr
            assign ctr_d[gi] = ctr_clear ? '0 : ctr_q[gi] + CTR_W'(inc[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCTR; i++) begin
                ctr_q[i]  <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCTR; i++) begin
                ctr_q[i] <= ctr_d[i];
                // Pre-update values: the snapshot ignores this edge's increment or clear.
                if (state_q == ST_SNAP) begin
                    snap_q[i] <= ctr_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        dump_wr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dump_req) begin
                    state_d = ST_SNAP;
                end
            end
            ST_SNAP: begin
                index_d = '0;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // The CPU always wins the port; the dump simply waits its turn.
                if (!cpu_mem_req) begin
                    dump_wr = 1'b1;
                    if (index_q == 3'd4) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        snap_word = 32'(snap_q[index_q]);
        if (dump_wr) begin
            web   = 4'b1111;
            addrb = BASE_ADDR + {27'd0, index_q, 2'b00};
            dib   = snap_word;
        end else begin
            web   = cpu_web;
            addrb = cpu_addrb;
            dib   = cpu_dib;
        end
    end

    assign clk_cycles           = ctr_q[0];
    assign invalid_clk_cycles   = ctr_q[1];
    assign retired_instructions = ctr_q[2];
    assign correct_predictions  = ctr_q[3];
    assign total_predictions    = ctr_q[4];

    assign dump_busy = (state_q == ST_SNAP) || (state_q == ST_WRITE);
    assign dump_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_perf_dump_ctrl.sv
// Directed testbench for perf_dump_ctrl: counters, dump sequencing, port arbitration,
// wrap-around (on a narrow-counter instance) and reset in the middle of a dump.
module tb_perf_dump_ctrl;

    logic        clk;
    logic        rst;
    logic        ctr_clear;
    logic        bubble;
    logic        retire;
    logic        br_resolved;
    logic        br_correct;
    logic        dump_req;
    logic        cpu_mem_req;
    logic [3:0]  cpu_web;
    logic [31:0] cpu_addrb;
    logic [31:0] cpu_dib;

    logic [3:0]  web;
    logic [31:0] addrb;
    logic [31:0] dib;
    logic [31:0] clk_cycles, invalid_clk_cycles, retired_instructions;
    logic [31:0] correct_predictions, total_predictions;
    logic        dump_busy, dump_done;

    logic [3:0]  s_web;
    logic [31:0] s_addrb, s_dib;
    logic [3:0]  s_clk_cycles, s_invalid, s_retired, s_correct, s_total;
    logic        s_busy, s_done;

    int checks;
    int errors;

    perf_dump_ctrl #(.BASE_ADDR(32'h4F00), .CTR_W(32)) u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .ctr_clear            (ctr_clear),
        .bubble               (bubble),
        .retire               (retire),
        .br_resolved          (br_resolved),
        .br_correct           (br_correct),
        .dump_req             (dump_req),
        .cpu_mem_req          (cpu_mem_req),
        .cpu_web              (cpu_web),
        .cpu_addrb            (cpu_addrb),
        .cpu_dib              (cpu_dib),
        .web                  (web),
        .addrb                (addrb),
        .dib                  (dib),
        .clk_cycles           (clk_cycles),
        .invalid_clk_cycles   (invalid_clk_cycles),
        .retired_instructions (retired_instructions),
        .correct_predictions  (correct_predictions),
        .total_predictions    (total_predictions),
        .dump_busy            (dump_busy),
        .dump_done            (dump_done)
    );

    // Narrow counters let the wrap-around boundary be reached in a few cycles.
    perf_dump_ctrl #(.BASE_ADDR(32'h4F00), .CTR_W(4)) u_dut4 (
        .clk                  (clk),
        .rst                  (rst),
        .ctr_clear            (ctr_clear),
        .bubble               (bubble),
        .retire               (retire),
        .br_resolved          (br_resolved),
        .br_correct           (br_correct),
        .dump_req             (1'b0),
        .cpu_mem_req          (cpu_mem_req),
        .cpu_web              (cpu_web),
        .cpu_addrb            (cpu_addrb),
        .cpu_dib              (cpu_dib),
        .web                  (s_web),
        .addrb                (s_addrb),
        .dib                  (s_dib),
        .clk_cycles           (s_clk_cycles),
        .invalid_clk_cycles   (s_invalid),
        .retired_instructions (s_retired),
        .correct_predictions  (s_correct),
        .total_predictions    (s_total),
        .dump_busy            (s_busy),
        .dump_done            (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; ctr_clear = 1'b0; bubble = 1'b0; retire = 1'b0;
        br_resolved = 1'b0; br_correct = 1'b0; dump_req = 1'b0; cpu_mem_req = 1'b0;
        cpu_web = 4'b1010; cpu_addrb = 32'h1234; cpu_dib = 32'hCAFE0001;
        tick; tick;
        checks += 8;
        if (clk_cycles !== 32'd0) begin errors++; $display("FAIL reset_clk got %0d want 0", clk_cycles); end
        if (invalid_clk_cycles !== 32'd0) begin errors++; $display("FAIL reset_inv got %0d want 0", invalid_clk_cycles); end
        if (retired_instructions !== 32'd0) begin errors++; $display("FAIL reset_ret got %0d want 0", retired_instructions); end
        if (correct_predictions !== 32'd0 || total_predictions !== 32'd0) begin
            errors++; $display("FAIL reset_pred got %0d/%0d want 0/0", correct_predictions, total_predictions);
        end
        if (dump_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", dump_busy); end
        if (dump_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", dump_done); end
        if (web !== 4'b1010 || addrb !== 32'h1234) begin
            errors++; $display("FAIL reset_port got web=%h addr=%h want web=a addr=1234", web, addrb);
        end
        if (dib !== 32'hCAFE0001) begin errors++; $display("FAIL reset_dib got %h want cafe0001", dib); end
        cpu_web = 4'b0000; cpu_addrb = 32'h0; cpu_dib = 32'h0;
        $display("test_reset done");
    endtask

    task automatic test_counts;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bubble = (i == 2 || i == 3);
            retire = !(i == 2 || i == 3);
            tick;
        end
        bubble = 1'b0; retire = 1'b0;
        checks += 3;
        if (clk_cycles !== 32'd10) begin errors++; $display("FAIL cnt_clk got %0d want 10", clk_cycles); end
        if (invalid_clk_cycles !== 32'd2) begin errors++; $display("FAIL cnt_inv got %0d want 2", invalid_clk_cycles); end
        if (retired_instructions !== 32'd8) begin errors++; $display("FAIL cnt_ret got %0d want 8", retired_instructions); end
        $display("test_counts clk=%0d inv=%0d ret=%0d", clk_cycles, invalid_clk_cycles, retired_instructions);
    endtask

    task automatic test_predictions;
        logic [7:0] res_pat;
        logic [7:0] cor_pat;
        res_pat = 8'b0011_1111;
        cor_pat = 8'b1100_1111;
        ctr_clear = 1'b1;
        tick;
        ctr_clear = 1'b0;
        checks++;
        if (clk_cycles !== 32'd0 || retired_instructions !== 32'd0) begin
            errors++; $display("FAIL clear got clk=%0d ret=%0d want 0/0", clk_cycles, retired_instructions);
        end
        for (int i = 0; i < 8; i++) begin
            br_resolved = res_pat[i];
            br_correct  = cor_pat[i];
            tick;
        end
        br_resolved = 1'b0; br_correct = 1'b0;
        checks += 3;
        if (total_predictions !== 32'd6) begin errors++; $display("FAIL pred_total got %0d want 6", total_predictions); end
        if (correct_predictions !== 32'd4) begin errors++; $display("FAIL pred_correct got %0d want 4", correct_predictions); end
        if (clk_cycles !== 32'd8) begin errors++; $display("FAIL pred_clk got %0d want 8", clk_cycles); end
        $display("test_predictions total=%0d correct=%0d", total_predictions, correct_predictions);
    endtask

    task automatic test_dump_uncontended;
        logic [31:0] exp_snap [5];
        int lat;
        exp_snap = '{32'd8, 32'd2, 32'd5, 32'd2, 32'd2};
        ctr_clear = 1'b1; tick; ctr_clear = 1'b0;
        retire = 1'b1; repeat (5) tick;
        retire = 1'b0; bubble = 1'b1; br_resolved = 1'b1; br_correct = 1'b1;
        repeat (2) tick;
        bubble = 1'b0; br_resolved = 1'b0; br_correct = 1'b0;
        dump_req = 1'b1; tick; dump_req = 1'b0; lat = 1;
        checks += 2;
        if (dump_busy !== 1'b1) begin errors++; $display("FAIL snap_busy got %b want 1", dump_busy); end
        if (web !== 4'b0000) begin errors++; $display("FAIL snap_noport got web=%h want 0", web); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) dump_req = 1'b1;
            if (i == 3) dump_req = 1'b0;
            tick; lat++;
            checks += 3;
            if (addrb !== 32'h4F00 + 32'(4 * i)) begin errors++; $display("FAIL wr%0d_addr got %h want %h", i, addrb, 32'h4F00 + 32'(4 * i)); end
            if (web !== 4'hF) begin errors++; $display("FAIL wr%0d_web got %h want f", i, web); end
            if (dib !== exp_snap[i]) begin errors++; $display("FAIL wr%0d_dib got %0d want %0d", i, dib, exp_snap[i]); end
            $display("dump write %0d addr=%h dib=%0d", i, addrb, dib);
        end
        while (dump_done !== 1'b1 && lat < 30) begin tick; lat++; end
        checks += 2;
        if (dump_done !== 1'b1) begin errors++; $display("FAIL done_seen got %b want 1", dump_done); end
        if (lat != 7) begin errors++; $display("FAIL done_latency got %0d want 7", lat); end
        tick;
        checks++;
        if (dump_done !== 1'b0 || dump_busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse got done=%b busy=%b want 0/0", dump_done, dump_busy);
        end
        tick;
        checks++;
        if (dump_busy !== 1'b0 || dump_done !== 1'b0) begin
            errors++; $display("FAIL req_ignored got busy=%b done=%b want 0/0", dump_busy, dump_done);
        end
        $display("test_dump_uncontended latency=%0d", lat);
    endtask

    task automatic test_dump_contended;
        logic [31:0] exp_snap [5];
        int lat;
        exp_snap = '{32'd4, 32'd0, 32'd3, 32'd0, 32'd0};
        ctr_clear = 1'b1; tick; ctr_clear = 1'b0;
        retire = 1'b1; repeat (3) tick; retire = 1'b0;
        dump_req = 1'b1; tick; dump_req = 1'b0; lat = 1;
        for (int i = 0; i < 2; i++) begin
            tick; lat++;
            checks++;
            if (addrb !== 32'h4F00 + 32'(4 * i) || dib !== exp_snap[i]) begin
                errors++; $display("FAIL cw%0d got addr=%h dib=%0d want %h/%0d", i, addrb, dib, 32'h4F00 + 32'(4 * i), exp_snap[i]);
            end
        end
        tick; lat++;
        cpu_mem_req = 1'b1; cpu_web = 4'b0011; cpu_addrb = 32'h100; cpu_dib = 32'hDEADBEEF;
        ctr_clear = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++;
            if (web !== 4'b0011 || addrb !== 32'h100 || dib !== 32'hDEADBEEF || dump_busy !== 1'b1) begin
                errors++; $display("FAIL stall%0d got web=%h addr=%h dib=%h busy=%b want 3/100/deadbeef/1", s, web, addrb, dib, dump_busy);
            end
            $display("stall cycle %0d web=%h addr=%h", s, web, addrb);
            tick; lat++;
            ctr_clear = 1'b0;
        end
        cpu_mem_req = 1'b0; cpu_web = 4'b0000; cpu_addrb = 32'h0; cpu_dib = 32'h0;
        #1;
        checks++;
        if (addrb !== 32'h4F08 || dib !== 32'd3 || web !== 4'hF) begin
            errors++; $display("FAIL resume got addr=%h dib=%0d web=%h want 4f08/3/f", addrb, dib, web);
        end
        for (int i = 3; i < 5; i++) begin
            tick; lat++;
            checks++;
            if (addrb !== 32'h4F00 + 32'(4 * i) || dib !== exp_snap[i] || web !== 4'hF) begin
                errors++; $display("FAIL cw%0d got addr=%h dib=%0d want %h/%0d", i, addrb, dib, 32'h4F00 + 32'(4 * i), exp_snap[i]);
            end
        end
        while (dump_done !== 1'b1 && lat < 40) begin tick; lat++; end
        checks++;
        if (dump_done !== 1'b1 || lat != 10) begin
            errors++; $display("FAIL contended_latency got %0d done=%b want 10", lat, dump_done);
        end
        $display("test_dump_contended latency=%0d", lat);
        tick;
    endtask

    task automatic test_wrap;
        ctr_clear = 1'b1; tick; ctr_clear = 1'b0;
        retire = 1'b1;
        repeat (15) tick;
        checks += 2;
        if (s_retired !== 4'hF || s_clk_cycles !== 4'hF) begin
            errors++; $display("FAIL wrap_pre got ret=%h clk=%h want f/f", s_retired, s_clk_cycles);
        end
        if (retired_instructions !== 32'd15) begin errors++; $display("FAIL wide_pre got %0d want 15", retired_instructions); end
        tick;
        checks += 2;
        if (s_retired !== 4'h0 || s_clk_cycles !== 4'h0) begin
            errors++; $display("FAIL wrap_roll got ret=%h clk=%h want 0/0", s_retired, s_clk_cycles);
        end
        if (retired_instructions !== 32'd16) begin errors++; $display("FAIL wide_roll got %0d want 16", retired_instructions); end
        ctr_clear = 1'b1;
        tick;
        ctr_clear = 1'b0; retire = 1'b0;
        checks += 2;
        if (retired_instructions !== 32'd0) begin errors++; $display("FAIL clear_prio got %0d want 0", retired_instructions); end
        if (s_retired !== 4'h0) begin errors++; $display("FAIL clear_prio_narrow got %0d want 0", s_retired); end
        $display("test_wrap narrow_ret=%0d wide_ret=%0d", s_retired, retired_instructions);
    endtask

    task automatic test_reset_mid_dump;
        retire = 1'b1;
        dump_req = 1'b1; tick; dump_req = 1'b0;
        repeat (4) tick;
        checks++;
        if (addrb !== 32'h4F0C) begin errors++; $display("FAIL mid_index3 got addr=%h want 4f0c", addrb); end
        rst = 1'b1; cpu_web = 4'b0101; cpu_addrb = 32'h200; cpu_dib = 32'h55;
        tick;
        checks += 4;
        if (dump_busy !== 1'b0 || dump_done !== 1'b0) begin
            errors++; $display("FAIL mid_rst_state got busy=%b done=%b want 0/0", dump_busy, dump_done);
        end
        if (clk_cycles !== 32'd0 || retired_instructions !== 32'd0) begin
            errors++; $display("FAIL mid_rst_ctr got clk=%0d ret=%0d want 0/0", clk_cycles, retired_instructions);
        end
        if (web !== 4'b0101 || addrb !== 32'h200) begin
            errors++; $display("FAIL mid_rst_port got web=%h addr=%h want 5/200", web, addrb);
        end
        if (dib !== 32'h55) begin errors++; $display("FAIL mid_rst_dib got %h want 55", dib); end
        rst = 1'b0; retire = 1'b0;
        tick;
        checks++;
        if (dump_busy !== 1'b0 || clk_cycles !== 32'd1) begin
            errors++; $display("FAIL post_rst got busy=%b clk=%0d want 0/1", dump_busy, clk_cycles);
        end
        $display("test_reset_mid_dump busy=%b clk=%0d", dump_busy, clk_cycles);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_counts;
        test_predictions;
        test_dump_uncontended;
        test_dump_contended;
        test_wrap;
        test_reset_mid_dump;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
